// File: rtl/combat_pkg.sv
// Shared types and helpers for the combat health/round controller.
// Holds the FSM state encoding and the saturating damage subtraction.
package combat_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FIGHT      = 2'd1,
        KO         = 2'd2,
        MATCH_OVER = 2'd3
    } combat_state_t;

    // Health bottoms out at zero instead of wrapping.
    function automatic logic [31:0] sat_sub(input logic [31:0] h, input logic [31:0] d);
        return (h > d) ? (h - d) : 32'd0;
    endfunction

endpackage

// File: rtl/player_health.sv
// One fighter's health bar and post-hit invulnerability counter.
// 'alive' reflects the post-update health so the round can end on the same tick.
module player_health
    import combat_pkg::*;
#(
    parameter int HEALTH_W   = 8,
    parameter int MAX_HEALTH = 200,
    parameter int HIT_DMG    = 10,
    parameter int CHIP_DMG   = 2,
    parameter int IFRAMES    = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_en,
    input  logic                hit,
    input  logic                block,
    input  logic                refill,
    output logic [HEALTH_W-1:0] health,
    output logic                invuln,
    output logic                alive
);

    localparam int CW = (IFRAMES > 0) ? $clog2(IFRAMES + 1) : 1;

    logic [HEALTH_W-1:0] health_q, health_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         dmg;

    always_comb begin
        health_d = health_q;
        cnt_d    = cnt_q;
        dmg      = block ? 32'(CHIP_DMG) : 32'(HIT_DMG);
        if (refill) begin
            health_d = HEALTH_W'(MAX_HEALTH);
            cnt_d    = '0;
        end else if (tick_en) begin
            if (hit && (cnt_q == '0)) begin
                health_d = HEALTH_W'(sat_sub(32'(health_q), dmg));
                cnt_d    = CW'(IFRAMES);
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            health_q <= HEALTH_W'(MAX_HEALTH);
            cnt_q    <= '0;
        end else begin
            health_q <= health_d;
            cnt_q    <= cnt_d;
        end
    end

    assign health = health_q;
    assign invuln = (cnt_q != '0);
    assign alive  = (health_d != '0);

endmodule

// File: rtl/combat_health_ctrl.sv
// Round/match sequencer for up to four fighters: KO detection, win counting,
// KO pause and best-of-N match completion around per-player health bars.
module combat_health_ctrl
    import combat_pkg::*;
#(
    parameter int  NUM_PLAYERS   = 2,
    parameter int  HEALTH_W      = 8,
    parameter int  MAX_HEALTH    = 200,
    parameter int  HIT_DMG       = 10,
    parameter int  CHIP_DMG      = 2,
    parameter int  IFRAMES       = 30,
    parameter int  ROUNDS_TO_WIN = 2,
    parameter int  KO_PAUSE      = 120,
    localparam int WW            = $clog2(ROUNDS_TO_WIN + 1),
    localparam int WINW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_tick,
    input  logic                            start,
    input  logic [NUM_PLAYERS-1:0]          hit,
    input  logic [NUM_PLAYERS-1:0]          block,
    output logic [NUM_PLAYERS*HEALTH_W-1:0] health,
    output logic [NUM_PLAYERS-1:0]          invuln,
    output logic [NUM_PLAYERS*WW-1:0]       round_wins,
    output logic [1:0]                      state,
    output logic [WINW-1:0]                 winner,
    output logic                            winner_valid
);

    localparam int PW = $clog2(KO_PAUSE + 1);

    combat_state_t                    state_q, state_d;
    logic [PW-1:0]                    pause_q, pause_d;
    logic [NUM_PLAYERS-1:0][WW-1:0]   wins_q, wins_d;
    logic [WINW-1:0]                  winner_q, winner_d;
    logic                             winner_valid_q, winner_valid_d;

    logic [NUM_PLAYERS-1:0] alive;
    logic [2:0]             alive_cnt;
    logic [WINW-1:0]        survivor;
    logic [WINW-1:0]        champ;
    logic                   champ_found;
    logic                   tick_en;
    logic                   refill;

    assign tick_en = frame_tick && (state_q == FIGHT);

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        player_health #(
            .HEALTH_W   (HEALTH_W),
            .MAX_HEALTH (MAX_HEALTH),
            .HIT_DMG    (HIT_DMG),
            .CHIP_DMG   (CHIP_DMG),
            .IFRAMES    (IFRAMES)
        ) u_player (
            .clk     (Clk),
            .rst     (Reset),
            .tick_en (tick_en),
            .hit     (hit[g]),
            .block   (block[g]),
            .refill  (refill),
            .health  (health[g*HEALTH_W +: HEALTH_W]),
            .invuln  (invuln[g]),
            .alive   (alive[g])
        );
    end

    always_comb begin
        alive_cnt   = '0;
        survivor    = '0;
        champ_found = 1'b0;
        champ       = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive[i]) begin
                alive_cnt = alive_cnt + 3'd1;
                survivor  = WINW'(i);
            end
            if (wins_q[i] == WW'(ROUNDS_TO_WIN)) begin
                champ_found = 1'b1;
                champ       = WINW'(i);
            end
        end
    end

    // Kept apart from the FSM so refill never depends on the players' alive flags.
    always_comb begin
        refill = 1'b0;
        case (state_q)
            IDLE, MATCH_OVER: refill = start;
            KO:               refill = frame_tick && (pause_q == PW'(KO_PAUSE - 1)) && !champ_found;
            default:          refill = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pause_d        = pause_q;
        wins_d         = wins_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;
        case (state_q)
            IDLE, MATCH_OVER: begin
                if (start) begin
                    state_d        = FIGHT;
                    wins_d         = '0;
                    winner_valid_d = 1'b0;
                end
            end
            FIGHT: begin
                if (frame_tick && (alive_cnt <= 3'd1)) begin
                    state_d = KO;
                    pause_d = '0;
                    if (alive_cnt == 3'd1) begin
                        wins_d[survivor] = wins_q[survivor] + WW'(1);
                    end
                end
            end
            KO: begin
                if (frame_tick) begin
                    pause_d = pause_q + PW'(1);
                    if (pause_q == PW'(KO_PAUSE - 1)) begin
                        if (champ_found) begin
                            state_d        = MATCH_OVER;
                            winner_d       = champ;
                            winner_valid_d = 1'b1;
                        end else begin
                            state_d = FIGHT;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= IDLE;
            pause_q        <= '0;
            wins_q         <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pause_q        <= pause_d;
            wins_q         <= wins_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
        end
    end

    assign state        = state_q;
    assign round_wins   = wins_q;
    assign winner       = winner_q;
    assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_combat_health_ctrl.sv
// Scoreboard bench: the driver pushes hand-computed expectations, and monitors
// pop and compare them one cycle after each stimulus (or at once for async reset).
module tb_combat_health_ctrl;

    typedef struct {
        string name;
        bit    sel;
        bit    imm;
        int    due;
        int    h0, h1, inv, w0, w1, st, wv, win;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        startA, tickA, startB, tickB;
    logic [1:0]  hitA, blockA, hitB, blockB;
    logic [15:0] healthA, healthB;
    logic [1:0]  invA, invB, stateA, stateB;
    logic [3:0]  winsA, winsB;
    logic [0:0]  winnerA, winnerB;
    logic        wvA, wvB;

    exp_t sb[$];
    int   mon_cyc = 0;
    int   n_vec   = 0;
    int   n_miss  = 0;
    event chk_now;

    always #5 Clk = ~Clk;

    // Default build.
    combat_health_ctrl u_dut_a (
        .Clk(Clk), .Reset(Reset), .frame_tick(tickA), .start(startA),
        .hit(hitA), .block(blockA), .health(healthA), .invuln(invA),
        .round_wins(winsA), .state(stateA), .winner(winnerA), .winner_valid(wvA)
    );

    // Short health bar, no invulnerability: saturation and double KO.
    combat_health_ctrl #(.MAX_HEALTH(15), .IFRAMES(0)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .frame_tick(tickB), .start(startB),
        .hit(hitB), .block(blockB), .health(healthB), .invuln(invB),
        .round_wins(winsB), .state(stateB), .winner(winnerB), .winner_valid(wvB)
    );

    function automatic void checkOutput(exp_t e);
        int a_h0, a_h1, a_inv, a_w0, a_w1, a_st, a_wv, a_win;
        if (!e.sel) begin
            a_h0 = int'(healthA[7:0]); a_h1 = int'(healthA[15:8]); a_inv = int'(invA);
            a_w0 = int'(winsA[1:0]);   a_w1 = int'(winsA[3:2]);    a_st  = int'(stateA);
            a_wv = int'(wvA);          a_win = int'(winnerA);
        end else begin
            a_h0 = int'(healthB[7:0]); a_h1 = int'(healthB[15:8]); a_inv = int'(invB);
            a_w0 = int'(winsB[1:0]);   a_w1 = int'(winsB[3:2]);    a_st  = int'(stateB);
            a_wv = int'(wvB);          a_win = int'(winnerB);
        end
        n_vec++;
        if (a_h0 != e.h0 || a_h1 != e.h1 || a_inv != e.inv || a_w0 != e.w0 || a_w1 != e.w1 ||
            a_st != e.st || a_wv != e.wv || a_win != e.win) begin
            n_miss++;
            $display("[TB] FAIL %s: got h0=%0d h1=%0d inv=%0d w0=%0d w1=%0d st=%0d wv=%0d win=%0d, want h0=%0d h1=%0d inv=%0d w0=%0d w1=%0d st=%0d wv=%0d win=%0d",
                     e.name, a_h0, a_h1, a_inv, a_w0, a_w1, a_st, a_wv, a_win,
                     e.h0, e.h1, e.inv, e.w0, e.w1, e.st, e.wv, e.win);
        end
    endfunction

    function automatic void push_exp(string name, bit sel, bit imm, int h0, int h1, int inv,
                                     int w0, int w1, int st, int wv, int win);
        exp_t e;
        e.name = name; e.sel = sel; e.imm = imm; e.due = mon_cyc + 2;
        e.h0 = h0; e.h1 = h1; e.inv = inv; e.w0 = w0; e.w1 = w1;
        e.st = st; e.wv = wv; e.win = win;
        sb.push_back(e);
    endfunction

    // Clocked monitor: expectations become due at the falling edge after the capturing edge.
    initial forever begin
        @(negedge Clk);
        mon_cyc++;
        while (sb.size() > 0 && !sb[0].imm && sb[0].due <= mon_cyc) checkOutput(sb.pop_front());
    end

    // Immediate monitor for asynchronous effects.
    initial forever begin
        @(chk_now);
        while (sb.size() > 0 && sb[0].imm) checkOutput(sb.pop_front());
    end

    // Drives one cycle of inputs to the selected DUT; the other DUT sees zeros.
    task automatic applyStimulus(input bit sel, input bit st, input bit tk,
                                 input logic [1:0] h, input logic [1:0] b);
        @(posedge Clk);
        #1;
        startA = 1'b0; tickA = 1'b0; hitA = 2'b00; blockA = 2'b00;
        startB = 1'b0; tickB = 1'b0; hitB = 2'b00; blockB = 2'b00;
        if (!sel) begin
            startA = st; tickA = tk; hitA = h; blockA = b;
        end else begin
            startB = st; tickB = tk; hitB = h; blockB = b;
        end
    endtask

    task automatic idle_ticks(input bit sel, input int n);
        repeat (n) applyStimulus(sel, 1'b0, 1'b1, 2'b00, 2'b00);
    endtask

    // Twenty accepted hits on player 1 with the invulnerability gap between them.
    task automatic ko_player1();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) idle_ticks(1'b0, 30);
            applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        end
    endtask

    initial begin
        Reset = 1'b1;
        startA = 1'b0; tickA = 1'b0; hitA = 2'b00; blockA = 2'b00;
        startB = 1'b0; tickB = 1'b0; hitB = 2'b00; blockB = 2'b00;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        applyStimulus(0, 0, 0, 2'b00, 2'b00); push_exp("reset_a", 0, 0, 200, 200, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 2'b00); push_exp("reset_b", 1, 0, 15, 15, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2'b01, 2'b00); push_exp("idle_tick", 0, 0, 200, 200, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 2'b11, 2'b00); push_exp("start_wins", 0, 0, 200, 200, 0, 0, 0, 1, 0, 0);

        // Unblocked hit and invulnerability window.
        applyStimulus(0, 0, 1, 2'b01, 2'b00); push_exp("hit0", 0, 0, 190, 200, 1, 0, 0, 1, 0, 0);
        idle_ticks(0, 4);
        applyStimulus(0, 0, 1, 2'b01, 2'b00); push_exp("iframe_ignore", 0, 0, 190, 200, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 2'b01, 2'b00); push_exp("no_tick_ignore", 0, 0, 190, 200, 1, 0, 0, 1, 0, 0);
        idle_ticks(0, 23);
        applyStimulus(0, 0, 1, 2'b00, 2'b00); push_exp("invuln_last", 0, 0, 190, 200, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 2'b01, 2'b00); push_exp("invuln_end", 0, 0, 190, 200, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 2'b01, 2'b00); push_exp("rehit", 0, 0, 180, 200, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 2'b10, 2'b10); push_exp("block_hit", 0, 0, 180, 198, 3, 0, 0, 1, 0, 0);

        // Round 1: player 1 from 198 down to 0.
        for (int k = 0; k < 20; k++) begin
            idle_ticks(0, 30);
            applyStimulus(0, 0, 1, 2'b10, 2'b00);
        end
        push_exp("ko1", 0, 0, 180, 0, 2, 1, 0, 2, 0, 0);
        idle_ticks(0, 118);
        applyStimulus(0, 0, 1, 2'b11, 2'b11); push_exp("ko_frozen", 0, 0, 180, 0, 2, 1, 0, 2, 0, 0);
        applyStimulus(0, 0, 1, 2'b00, 2'b00); push_exp("round2_start", 0, 0, 200, 200, 0, 1, 0, 1, 0, 0);

        // Round 2 ends the match.
        ko_player1();
        push_exp("ko2", 0, 0, 200, 0, 2, 2, 0, 2, 0, 0);
        idle_ticks(0, 119);
        applyStimulus(0, 0, 1, 2'b00, 2'b00); push_exp("match_over", 0, 0, 200, 0, 2, 2, 0, 3, 1, 0);
        applyStimulus(0, 0, 1, 2'b01, 2'b00); push_exp("mo_hold", 0, 0, 200, 0, 2, 2, 0, 3, 1, 0);
        applyStimulus(0, 1, 1, 2'b01, 2'b00); push_exp("restart", 0, 0, 200, 200, 0, 0, 0, 1, 0, 0);

        // Saturation and simultaneous KO on the short-bar build.
        applyStimulus(1, 1, 0, 2'b00, 2'b00); push_exp("b_start", 1, 0, 15, 15, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 2'b01, 2'b00); push_exp("b_hit1", 1, 0, 5, 15, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 2'b01, 2'b00); push_exp("b_sat", 1, 0, 0, 15, 0, 0, 1, 2, 0, 0);
        idle_ticks(1, 119);
        applyStimulus(1, 0, 1, 2'b00, 2'b00); push_exp("b_round2", 1, 0, 15, 15, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 2'b11, 2'b00); push_exp("b_both1", 1, 0, 5, 5, 0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 2'b11, 2'b00); push_exp("b_double_ko", 1, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        idle_ticks(1, 119);
        applyStimulus(1, 0, 1, 2'b00, 2'b00); push_exp("b_round3", 1, 0, 15, 15, 0, 0, 1, 1, 0, 0);

        // Asynchronous reset in the middle of a KO pause.
        ko_player1();
        push_exp("ko3", 0, 0, 200, 0, 2, 1, 0, 2, 0, 0);
        idle_ticks(0, 60);
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        push_exp("async_reset", 0, 1, 200, 200, 0, 0, 0, 0, 0, 0);
        ->chk_now;
        #1;
        applyStimulus(0, 0, 0, 2'b00, 2'b00);
        Reset = 1'b0;

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge Clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
